// File: rtl/output_counter_gen_pkg.sv
// Shared constants, channel state type and helpers for the output_counter_gen block.
// Optional wrap-event counter is enabled by defining OUTPUT_COUNTER_GEN_WRAPCNT_EN.
package output_counter_gen_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_STOP = 1'b1;
  localparam int   WRAPCNT_W = 8;

  typedef enum logic {
    CH_RUN  = 1'b0,
    CH_DONE = 1'b1
  } chState_e;

  // Saturating increment used by the wrap-event counter; sticks at all-ones.
  function automatic logic [WRAPCNT_W-1:0] satInc(input logic [WRAPCNT_W-1:0] value);
    return (value == {WRAPCNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/output_counter_gen_if.sv
// Control/status bundle of the multi-channel counter; the master side drives controls.
// The o_wrap_cnt field exists only when OUTPUT_COUNTER_GEN_WRAPCNT_EN is defined.
interface output_counter_gen_if #(
  parameter int W    = 3,
  parameter int N_CH = 1
);
  import output_counter_gen_pkg::*;

  logic [N_CH-1:0]           En_o_count;
  logic [N_CH-1:0]           Clr_o_count;
  logic [N_CH-1:0]           Ld_o_count;
  logic [W-1:0]              Ld_val;
  logic [W-1:0]              Term_val;
  logic                      Mode;
  logic [N_CH*W-1:0]         o_count_out;
  logic [N_CH-1:0]           o_tc;
  logic [N_CH-1:0]           o_done;
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
  logic [N_CH*WRAPCNT_W-1:0] o_wrap_cnt;
`endif

  modport master (
    output En_o_count, Clr_o_count, Ld_o_count, Ld_val, Term_val, Mode,
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
    input  o_wrap_cnt,
`endif
    input  o_count_out, o_tc, o_done
  );

  modport slave (
    input  En_o_count, Clr_o_count, Ld_o_count, Ld_val, Term_val, Mode,
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
    output o_wrap_cnt,
`endif
    output o_count_out, o_tc, o_done
  );

endinterface

// File: rtl/output_counter_ch.sv
// One counter channel: count, terminal-count pulse, sticky done state.
// Adds a saturating wrap-event counter when OUTPUT_COUNTER_GEN_WRAPCNT_EN is defined.
module output_counter_ch
  import output_counter_gen_pkg::*;
#(
  parameter int W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 ld_i,
  input  logic [W-1:0]         ld_val_i,
  input  logic [W-1:0]         term_val_i,
  input  logic                 mode_i,
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
  output logic [WRAPCNT_W-1:0] wrap_cnt_o,
`endif
  output logic [W-1:0]         count_o,
  output logic                 tc_o,
  output logic                 done_o
);

  logic [W-1:0] count_q;
  logic         tc_q;
  chState_e     state_q;
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
  logic [WRAPCNT_W-1:0] wrap_q;
`endif

  // tc_q defaults low each cycle so it only pulses after an En-qualified terminal hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      state_q <= CH_RUN;
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
      wrap_q  <= '0;
`endif
    end else begin
      tc_q <= 1'b0;
      if (clr_i) begin
        count_q <= '0;
        state_q <= CH_RUN;
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
        wrap_q  <= '0;
`endif
      end else if (ld_i) begin
        count_q <= ld_val_i;
        state_q <= CH_RUN;
      end else if (en_i && (state_q == CH_RUN)) begin
        if (count_q == term_val_i) begin
          tc_q <= 1'b1;
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
          wrap_q <= satInc(wrap_q);
`endif
          if (mode_i == MODE_STOP) begin
            state_q <= CH_DONE;
          end else begin
            count_q <= '0;
          end
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = (state_q == CH_DONE);
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
  assign wrap_cnt_o = wrap_q;
`endif

endmodule

// File: rtl/output_counter_gen.sv
// N_CH independent counters sharing load/terminal/mode controls.
// Define OUTPUT_COUNTER_GEN_WRAPCNT_EN to add the per-channel o_wrap_cnt output.
module output_counter_gen
  import output_counter_gen_pkg::*;
#(
  parameter int W    = 3,
  parameter int N_CH = 1
) (
  input  logic                 Clock,
  input  logic                 Res_o_count,
  output_counter_gen_if.slave  bus
);

  logic [N_CH-1:0][W-1:0] countArr;
  logic [N_CH-1:0]        tcVec;
  logic [N_CH-1:0]        doneVec;
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
  logic [N_CH-1:0][WRAPCNT_W-1:0] wrapArr;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    output_counter_ch #(
      .W (W)
    ) uCh (
      .clk        (Clock),
      .rst_n      (Res_o_count),
      .en_i       (bus.En_o_count[i]),
      .clr_i      (bus.Clr_o_count[i]),
      .ld_i       (bus.Ld_o_count[i]),
      .ld_val_i   (bus.Ld_val),
      .term_val_i (bus.Term_val),
      .mode_i     (bus.Mode),
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
      .wrap_cnt_o (wrapArr[i]),
`endif
      .count_o    (countArr[i]),
      .tc_o       (tcVec[i]),
      .done_o     (doneVec[i])
    );
  end

  assign bus.o_count_out = countArr;
  assign bus.o_tc        = tcVec;
  assign bus.o_done      = doneVec;
`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
  assign bus.o_wrap_cnt  = wrapArr;
`endif

endmodule

// File: tb/tb_output_counter_gen.sv
// Directed bench for output_counter_gen (W=3, N_CH=2) with hand-computed expectations.
// The wrap-counter section runs only when OUTPUT_COUNTER_GEN_WRAPCNT_EN is defined.
module tb_output_counter_gen;
  import output_counter_gen_pkg::*;

  localparam int W    = 3;
  localparam int N_CH = 2;

  logic clock;
  logic resetN;
  int   vectorCount = 0;
  int   missCount   = 0;

  output_counter_gen_if #(.W(W), .N_CH(N_CH)) bus ();

  output_counter_gen #(.W(W), .N_CH(N_CH)) dut (
    .Clock       (clock),
    .Res_o_count (resetN),
    .bus         (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int wrapCnts[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int wrapTcs[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
  int stopCnts[6] = '{1, 2, 3, 3, 3, 3};
  int stopDone[6] = '{0, 0, 0, 1, 1, 1};
  int stopTcs[6]  = '{0, 0, 0, 1, 0, 0};
  int bigLdCnts[4] = '{0, 1, 2, 0};
  int bigLdTcs[4]  = '{0, 0, 0, 1};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of controls, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [1:0] en, input logic [1:0] clr, input logic [1:0] ld,
                               input logic [2:0] ldVal, input logic [2:0] term, input logic mode);
    bus.En_o_count  = en;
    bus.Clr_o_count = clr;
    bus.Ld_o_count  = ld;
    bus.Ld_val      = ldVal;
    bus.Term_val    = term;
    bus.Mode        = mode;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] cnt(input int ch);
    return bus.o_count_out[ch*W +: W];
  endfunction

  initial begin
    resetN          = 1'b1;
    bus.En_o_count  = '0;
    bus.Clr_o_count = '0;
    bus.Ld_o_count  = '0;
    bus.Ld_val      = '0;
    bus.Term_val    = '0;
    bus.Mode        = MODE_WRAP;
    #2 resetN = 1'b0;
    #1;
    checkOutput("reset_count", bus.o_count_out, 0);
    checkOutput("reset_tc",    bus.o_tc,        0);
    checkOutput("reset_done",  bus.o_done,      0);
    repeat (2) @(posedge clock);
    @(negedge clock) resetN = 1'b1;

    // Wrap mode, Term=5
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd5, MODE_WRAP);
      checkOutput($sformatf("wrap_cnt[%0d]", i), cnt(0), wrapCnts[i]);
      checkOutput($sformatf("wrap_tc[%0d]", i), bus.o_tc[0], wrapTcs[i]);
    end
    checkOutput("wrap_ch1_idle", cnt(1), 0);

    // Stop mode, Term=3
    applyStimulus(2'b00, 2'b01, 2'b00, 3'd0, 3'd3, MODE_STOP);
    checkOutput("clr_cnt", cnt(0), 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd3, MODE_STOP);
      checkOutput($sformatf("stop_cnt[%0d]", i), cnt(0), stopCnts[i]);
      checkOutput($sformatf("stop_done[%0d]", i), bus.o_done[0], stopDone[i]);
      checkOutput($sformatf("stop_tc[%0d]", i), bus.o_tc[0], stopTcs[i]);
    end
    applyStimulus(2'b00, 2'b00, 2'b01, 3'd2, 3'd3, MODE_STOP);
    checkOutput("ld2_cnt",  cnt(0), 2);
    checkOutput("ld2_done", bus.o_done[0], 0);

    // Ld of Term_val must not pulse o_tc
    applyStimulus(2'b00, 2'b00, 2'b01, 3'd3, 3'd3, MODE_STOP);
    checkOutput("ldterm_cnt", cnt(0), 3);
    checkOutput("ldterm_tc",  bus.o_tc[0], 0);
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd3, MODE_STOP);
    checkOutput("ldterm_en_tc",   bus.o_tc[0], 1);
    checkOutput("ldterm_en_done", bus.o_done[0], 1);

    // Mode change keeps done; En ignored while done
    applyStimulus(2'b00, 2'b00, 2'b00, 3'd0, 3'd3, MODE_WRAP);
    checkOutput("modechg_done", bus.o_done[0], 1);
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd3, MODE_WRAP);
    checkOutput("doneign_cnt",  cnt(0), 3);
    checkOutput("doneign_tc",   bus.o_tc[0], 0);
    checkOutput("doneign_done", bus.o_done[0], 1);

    // Channel independence: ch0 Clr+Ld+En, ch1 Ld only
    applyStimulus(2'b01, 2'b01, 2'b11, 3'd6, 3'd3, MODE_WRAP);
    checkOutput("indep_cnt0", cnt(0), 0);
    checkOutput("indep_cnt1", cnt(1), 6);
    checkOutput("indep_tc",   bus.o_tc, 0);
    checkOutput("indep_done", bus.o_done, 0);

    // Ld_val above Term_val wraps through 2^W-1
    applyStimulus(2'b00, 2'b00, 2'b01, 3'd7, 3'd2, MODE_WRAP);
    checkOutput("bigld_cnt", cnt(0), 7);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 3'd7, 3'd2, MODE_WRAP);
      checkOutput($sformatf("bigld_cnt[%0d]", i), cnt(0), bigLdCnts[i]);
      checkOutput($sformatf("bigld_tc[%0d]", i), bus.o_tc[0], bigLdTcs[i]);
    end

    // Term=0 in wrap mode
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd0, MODE_WRAP);
      checkOutput($sformatf("term0_cnt[%0d]", i), cnt(0), 0);
      checkOutput($sformatf("term0_tc[%0d]", i), bus.o_tc[0], 1);
    end

    // Reset pulsed mid-cycle while at count 4 in done
    applyStimulus(2'b00, 2'b01, 2'b00, 3'd0, 3'd4, MODE_STOP);
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd4, MODE_STOP);
    checkOutput("prerst_cnt",  cnt(0), 4);
    checkOutput("prerst_done", bus.o_done[0], 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midrst_count", bus.o_count_out, 0);
    checkOutput("midrst_tc",    bus.o_tc, 0);
    checkOutput("midrst_done",  bus.o_done, 0);
    #2 resetN = 1'b1;
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd4, MODE_STOP);
    checkOutput("postrst_cnt",  cnt(0), 1);
    checkOutput("postrst_done", bus.o_done[0], 0);

`ifdef OUTPUT_COUNTER_GEN_WRAPCNT_EN
    applyStimulus(2'b00, 2'b01, 2'b00, 3'd0, 3'd0, MODE_WRAP);
    checkOutput("wc_clr0", bus.o_wrap_cnt[7:0], 0);
    for (int i = 0; i < 255; i++) applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd0, MODE_WRAP);
    checkOutput("wc_255", bus.o_wrap_cnt[7:0], 255);
    for (int i = 0; i < 45; i++) applyStimulus(2'b01, 2'b00, 2'b00, 3'd0, 3'd0, MODE_WRAP);
    checkOutput("wc_sat", bus.o_wrap_cnt[7:0], 255);
    checkOutput("wc_ch1", bus.o_wrap_cnt[15:8], 0);
    applyStimulus(2'b00, 2'b00, 2'b01, 3'd1, 3'd0, MODE_WRAP);
    checkOutput("wc_ld_keep", bus.o_wrap_cnt[7:0], 255);
    applyStimulus(2'b00, 2'b01, 2'b00, 3'd0, 3'd0, MODE_WRAP);
    checkOutput("wc_clr", bus.o_wrap_cnt[7:0], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/output_counter_gen.md
OUTPUT_COUNTER_GEN -- requirements
Module: output_counter_gen

Interface
REQ-001 SHALL have parameter W, default 3: counter width per channel, range 2..16.
REQ-002 SHALL have parameter N_CH, default 1: number of independent counter channels, range 1..8.
REQ-003 SHALL have port Clock, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port Res_o_count, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port En_o_count, input, N_CH: per-channel count enable.
REQ-006 SHALL have port Clr_o_count, input, N_CH: per-channel synchronous clear, active-high.
REQ-007 SHALL have port Ld_o_count, input, N_CH: per-channel synchronous load, active-high.
REQ-008 SHALL have port Ld_val, input, W: load value, shared by all channels.
REQ-009 SHALL have port Term_val, input, W: terminal value, shared by all channels.
REQ-010 SHALL have port Mode, input, 1: 0 = wrap, 1 = stop; shared by all channels.
REQ-011 SHALL have port o_count_out, output, N_CH*W: packed counts; channel i occupies [i*W +: W].
REQ-012 SHALL have port o_tc, output, N_CH: terminal-count pulse per channel.
REQ-013 SHALL have port o_done, output, N_CH: sticky done flag per channel.

Function
REQ-014 Each channel SHALL apply this priority per cycle: Clr > Ld > En > hold.
REQ-015 Clr SHALL set the count to 0 and clear o_done.
REQ-016 Ld SHALL set the count to Ld_val and clear o_done.
REQ-017 En with o_done=0 and count != Term_val SHALL increment the count by 1, modulo 2^W.
REQ-018 Wrap mode, En with count == Term_val: next count SHALL be 0 (modulus Term_val+1).
REQ-019 Stop mode, En with count == Term_val: count SHALL hold and o_done SHALL set.
REQ-020 While o_done=1, En SHALL be ignored until Clr or Ld occurs.
REQ-021 o_tc SHALL be registered and high for exactly one cycle, in the cycle after an En-qualified cycle in which count == Term_val.
REQ-022 o_tc SHALL NOT assert on a Clr, a Ld, or a held cycle, including a Ld of Term_val.
REQ-023 Ld_val > Term_val SHALL count up through 2^W-1, wrap naturally to 0, and then continue normally.
REQ-024 Term_val == 0 in wrap mode SHALL keep the count at 0 and assert o_tc on every En cycle.
REQ-025 A change of Mode or Term_val SHALL take effect on the next edge; o_done SHALL NOT be cleared by such a change.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels SHALL NOT interact.
REQ-027 Each channel SHALL have two states, RUN (o_done=0) and DONE (o_done=1):
- RUN -> DONE on the REQ-019 condition.
- DONE -> RUN on Clr or Ld.

Reset
REQ-028 Res_o_count low SHALL immediately force all o_count_out, o_tc and o_done bits to 0, independent of Clock.
REQ-029 Reset asserted mid-count or in DONE SHALL discard all state; counting SHALL resume from 0 on the first En edge after release.

Configuration
REQ-030 With OUTPUT_COUNTER_GEN_WRAPCNT_EN defined, the block SHALL add output o_wrap_cnt, N_CH*8:
- per-channel count of o_tc events, saturating at 255;
- cleared by Clr or reset, not by Ld.
REQ-031 Without OUTPUT_COUNTER_GEN_WRAPCNT_EN, o_wrap_cnt and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package output_counter_gen_pkg SHALL hold MODE_WRAP=1'b0, MODE_STOP=1'b1 and the WRAPCNT_W=8 constant.
REQ-033 One sub-module, output_counter_ch (a single channel holding count, o_tc, o_done and optional wrap count), SHALL be instantiated N_CH times by generate.

Verification
REQ-034 W=3, N_CH=1, Term=5, wrap, En held 8 cycles -> counts 1,2,3,4,5,0,1,2; o_tc high exactly once, the cycle count shows 0.
REQ-035 W=3, Term=3, stop, En held 6 cycles -> counts 1,2,3,3,3,3; o_done rises with the first held 3; o_tc is one pulse; Ld 2 -> count 2, o_done 0.
REQ-036 Channel 0 with Clr, Ld and En all asserted together -> count 0; the same cycle on channel 1 with Ld only (Ld_val=6) -> 6; neither o_tc asserts.
REQ-037 Reset pulsed low between edges at count 4 with o_done=1 -> all outputs 0 before the next edge; after release, one En -> count 1.
REQ-038 Ld_val=7, Term=2, wrap, W=3, En 4 cycles -> 0,1,2,0 with a single o_tc.
REQ-039 With WRAPCNT_EN, Term=0, wrap, En held 300 cycles -> o_wrap_cnt reaches and holds 255; Clr returns it to 0.
